// File: rtl/x_core_rv32i_mc_if.sv
// Shared instruction/data memory bus for x_core_rv32i_mc (valid/accept handshake).
interface x_core_rv32i_mc_if;
   logic        o_valid;
   logic        o_we;
   logic [31:0] o_addr;
   logic [31:0] o_data;
   logic [31:0] i_data;
   logic        i_accept;

   modport master (
      output o_valid, o_we, o_addr, o_data,
      input  i_data, i_accept
   );

   modport slave (
      input  o_valid, o_we, o_addr, o_data,
      output i_data, i_accept
   );
endinterface

// File: rtl/x_core_rv32i_mc.sv
// Multi-cycle RV32I core (word loads/stores only) on a single shared memory bus.
// Define X_CORE_RV32I_MC_TRAP_EN to halt on illegal instructions instead of retiring them as NOPs.
module x_core_rv32i_mc #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned NUM_REGS        = 32,
   parameter bit          BYTE_ADDR_CHECK = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   x_core_rv32i_mc_if.master     bus,
   output logic                  o_retire,
   output logic                  o_trap
);

   localparam int unsigned RegW = $clog2(NUM_REGS);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

`ifdef X_CORE_RV32I_MC_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMem, StHalt} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d;
   logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, addr_q, addr_d;
   logic        illegal_q, illegal_d;
   logic [31:0] regs_q [NUM_REGS];

   logic [6:0]      opcode, funct7;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      funct3;
   logic [RegW-1:0] rd_a, rs1_a, rs2_a;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];
   assign rd_a   = rd[RegW-1:0];
   assign rs1_a  = rs1[RegW-1:0];
   assign rs2_a  = rs2[RegW-1:0];

   // Decode: immediate format, legality and register-index range.
   logic [31:0] imm_dec;
   logic        uses_rd, uses_rs1, uses_rs2, legal_op, dec_illegal;

   always_comb begin
      imm_dec  = '0;
      uses_rd  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      legal_op = 1'b0;
      case (opcode)
         OpLui, OpAuipc: begin
            imm_dec  = {ir_q[31:12], 12'b0};
            uses_rd  = 1'b1;
            legal_op = 1'b1;
         end
         OpJal: begin
            imm_dec  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            uses_rd  = 1'b1;
            legal_op = 1'b1;
         end
         OpJalr, OpLoad: begin
            imm_dec  = {{20{ir_q[31]}}, ir_q[31:20]};
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            legal_op = (opcode == OpJalr) ? (funct3 == 3'b000) : (funct3 == 3'b010);
         end
         OpBranch: begin
            imm_dec  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal_op = (funct3[2:1] != 2'b01);
         end
         OpStore: begin
            imm_dec  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal_op = (funct3 == 3'b010);
         end
         OpImm: begin
            imm_dec  = {{20{ir_q[31]}}, ir_q[31:20]};
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            if (funct3 == 3'b001)      legal_op = (funct7 == 7'h00);
            else if (funct3 == 3'b101) legal_op = (funct7 == 7'h00) || (funct7 == 7'h20);
            else                       legal_op = 1'b1;
         end
         OpReg: begin
            uses_rd  = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal_op = (funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         default: ;
      endcase
      dec_illegal = !legal_op ||
                    (uses_rd  && ({27'b0, rd}  >= NUM_REGS)) ||
                    (uses_rs1 && ({27'b0, rs1} >= NUM_REGS)) ||
                    (uses_rs2 && ({27'b0, rs2} >= NUM_REGS));
   end

   logic [31:0] rs1_rd, rs2_rd;
   assign rs1_rd = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1_a];
   assign rs2_rd = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2_a];

   // Execute datapath, all from the operand registers latched in DECODE.
   logic [31:0] op_b, alu, ea, pc_imm, pc_4;
   logic        is_reg, taken, misaligned;

   assign is_reg = (opcode == OpReg);
   assign op_b   = is_reg ? rs2_q : imm_q;
   assign ea     = rs1_q + imm_q;
   assign pc_imm = pc_q + imm_q;
   assign pc_4   = pc_q + 32'd4;

   always_comb begin
      alu = '0;
      case (funct3)
         3'b000: alu = (is_reg && ir_q[30]) ? (rs1_q - op_b) : (rs1_q + op_b);
         3'b001: alu = rs1_q << op_b[4:0];
         3'b010: alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
         3'b011: alu = {31'b0, rs1_q < op_b};
         3'b100: alu = rs1_q ^ op_b;
         3'b101: alu = ir_q[30] ? 32'($signed(rs1_q) >>> op_b[4:0]) : (rs1_q >> op_b[4:0]);
         3'b110: alu = rs1_q | op_b;
         default: alu = rs1_q & op_b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_q == rs2_q);
         3'b001:  taken = (rs1_q != rs2_q);
         3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
         3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
         3'b110:  taken = (rs1_q <  rs2_q);
         3'b111:  taken = (rs1_q >= rs2_q);
         default: taken = 1'b0;
      endcase
   end

   // Targets are always word-masked; with the check on, a set bit 1 traps before use.
   assign misaligned = BYTE_ADDR_CHECK &&
      ((((opcode == OpJal) || ((opcode == OpBranch) && taken)) && pc_imm[1]) ||
       ((opcode == OpJalr) && ea[1]) ||
       (((opcode == OpLoad) || (opcode == OpStore)) && (ea[1:0] != 2'b00)));

   logic        wr_en, retire;
   logic [31:0] wr_data;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      imm_d     = imm_q;
      addr_d    = addr_q;
      illegal_d = illegal_q;
      wr_en     = 1'b0;
      wr_data   = '0;
      retire    = 1'b0;
      case (state_q)
         StFetch: begin
            if (bus.i_accept) begin
               ir_d    = bus.i_data;
               state_d = StDecode;
            end
         end
         StDecode: begin
            rs1_d     = rs1_rd;
            rs2_d     = rs2_rd;
            imm_d     = imm_dec;
            illegal_d = dec_illegal;
            state_d   = (dec_illegal && TrapEn) ? StHalt : StExecute;
         end
         StExecute: begin
            if (illegal_q || misaligned) begin
               if (TrapEn) begin
                  state_d = StHalt;
               end else begin
                  pc_d    = pc_4;
                  retire  = 1'b1;
                  state_d = StFetch;
               end
            end else begin
               state_d = StFetch;
               pc_d    = pc_4;
               retire  = 1'b1;
               wr_en   = 1'b1;
               case (opcode)
                  OpLui:   wr_data = imm_q;
                  OpAuipc: wr_data = pc_imm;
                  OpJal: begin
                     wr_data = pc_4;
                     pc_d    = {pc_imm[31:2], 2'b00};
                  end
                  OpJalr: begin
                     wr_data = pc_4;
                     pc_d    = {ea[31:2], 2'b00};
                  end
                  OpBranch: begin
                     wr_en = 1'b0;
                     if (taken) pc_d = {pc_imm[31:2], 2'b00};
                  end
                  OpLoad, OpStore: begin
                     wr_en   = 1'b0;
                     retire  = 1'b0;
                     pc_d    = pc_q;
                     addr_d  = {ea[31:2], 2'b00};
                     state_d = StMem;
                  end
                  default: wr_data = alu;
               endcase
            end
         end
         StMem: begin
            if (bus.i_accept) begin
               if (opcode == OpLoad) begin
                  wr_en   = 1'b1;
                  wr_data = bus.i_data;
               end
               pc_d    = pc_4;
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         addr_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else if (wr_en && (rd != 5'd0)) begin
         regs_q[rd_a] <= wr_data;
      end
   end

   // Outputs are forced idle while reset is asserted so an in-flight request is dropped.
   always_comb begin
      bus.o_valid = 1'b0;
      bus.o_we    = 1'b0;
      bus.o_addr  = '0;
      bus.o_data  = '0;
      o_retire    = 1'b0;
      o_trap      = 1'b0;
      if (!i_rst) begin
         o_retire = retire;
         case (state_q)
            StFetch: begin
               bus.o_valid = 1'b1;
               bus.o_addr  = pc_q;
            end
            StMem: begin
               bus.o_valid = 1'b1;
               bus.o_we    = (opcode == OpStore);
               bus.o_addr  = addr_q;
               bus.o_data  = (opcode == OpStore) ? rs2_q : 32'd0;
            end
            StHalt:  o_trap = TrapEn;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_x_core_rv32i_mc.sv
// Directed bench for x_core_rv32i_mc: drives a hand-assembled program over the bus and
// checks fetch addresses, latencies, store data, retire count and reset/illegal handling.
module tb_x_core_rv32i_mc;
   logic i_clk;
   logic i_rst;
   logic o_retire;
   logic o_trap;
   int   n_cmp;
   int   n_err;
   int   n_ret;

   x_core_rv32i_mc_if bus ();

   x_core_rv32i_mc #(
      .RESET_PC        (32'h0000_0000),
      .NUM_REGS        (32),
      .BYTE_ADDR_CHECK (1'b1)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .bus      (bus),
      .o_retire (o_retire),
      .o_trap   (o_trap)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (i_rst) n_ret <= 0;
      else if (o_retire === 1'b1) n_ret <= n_ret + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a pending request; exp_wait < 0 skips the latency check.
   task automatic wait_req(input string tag, input int exp_wait);
      int n;
      n = 0;
      while (bus.o_valid !== 1'b1 && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      if (exp_wait >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_wait));
   endtask

   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input int exp_wait);
      wait_req(tag, exp_wait);
      chk({tag, "_addr"}, bus.o_addr, addr);
      chk({tag, "_we"}, 32'(bus.o_we), 32'd0);
      bus.i_accept = 1'b1;
      bus.i_data   = instr;
      @(negedge i_clk);
      bus.i_accept = 1'b0;
      bus.i_data   = '0;
   endtask

   task automatic mem(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input int stall, input logic [31:0] rdata);
      wait_req(tag, 2);
      chk({tag, "_we"}, 32'(bus.o_we), 32'(we));
      chk({tag, "_addr"}, bus.o_addr, addr);
      chk({tag, "_data"}, bus.o_data, data);
      for (int i = 0; i < stall; i++) begin
         @(negedge i_clk);
         chk({tag, "_hold_v"}, 32'(bus.o_valid), 32'd1);
         chk({tag, "_hold_a"}, bus.o_addr, addr);
         chk({tag, "_hold_d"}, bus.o_data, data);
         chk({tag, "_hold_w"}, 32'(bus.o_we), 32'(we));
      end
      bus.i_accept = 1'b1;
      bus.i_data   = rdata;
      @(negedge i_clk);
      bus.i_accept = 1'b0;
      bus.i_data   = '0;
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      i_rst        = 1'b1;
      bus.i_accept = 1'b0;
      bus.i_data   = '0;
      repeat (2) @(negedge i_clk);
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_addr", bus.o_addr, 32'd0);
      chk("rst_trap", 32'(o_trap), 32'd0);
      i_rst = 1'b0;
      #1;

      // ADDI x1,x0,5
      fetch("f0", 32'h00, 32'h00500093, 0);
      fetch("f4", 32'h04, 32'hFFF00113, 2);   // ADDI x2,x0,-1
      chk("ret_first", 32'(n_ret), 32'd1);
      fetch("f8", 32'h08, 32'h40415193, 2);   // SRAI x3,x2,4
      fetch("fc", 32'h0C, 32'h01C15213, 2);   // SRLI x4,x2,28
      fetch("f10", 32'h10, 32'h00302023, 2);  // SW x3,0(x0)
      mem("sw_x3", 1'b1, 32'd0, 32'hFFFF_FFFF, 0, 32'd0);
      fetch("f14", 32'h14, 32'h00402223, 0);  // SW x4,4(x0)
      mem("sw_x4", 1'b1, 32'd4, 32'h0000_000F, 0, 32'd0);

      fetch("f18", 32'h18, 32'h00114463, 0);  // BLT x2,x1,+8 (taken)
      fetch("f20", 32'h20, 32'h00116463, 2);  // BLTU x2,x1,+8 (not taken)

      fetch("f24", 32'h24, 32'h00102623, 2);  // SW x1,12(x0)
      mem("sw_x1", 1'b1, 32'd12, 32'd5, 3, 32'd0);
      fetch("f28", 32'h28, 32'h00C02283, 0);  // LW x5,12(x0)
      mem("lw_x5", 1'b0, 32'd12, 32'd0, 3, 32'hDEAD_BEEF);
      fetch("f2c", 32'h2C, 32'h00502823, 0);  // SW x5,16(x0)
      mem("sw_x5", 1'b1, 32'd16, 32'hDEAD_BEEF, 0, 32'd0);

      fetch("f30", 32'h30, 32'h010000EF, 0);  // JAL x1,+16
      fetch("f40j", 32'h40, 32'h00008067, 2); // JALR x0,0(x1)
      fetch("f34", 32'h34, 32'h00700013, 2);  // ADDI x0,x0,7
      fetch("f38", 32'h38, 32'h00002A23, 2);  // SW x0,20(x0)
      mem("sw_x0", 1'b1, 32'd20, 32'd0, 0, 32'd0);
      fetch("f3c", 32'h3C, 32'h00102C23, 0);  // SW x1,24(x0)
      mem("sw_lnk", 1'b1, 32'd24, 32'h34, 0, 32'd0);

      fetch("f40", 32'h40, 32'h12345337, 0);  // LUI x6,0x12345
      fetch("f44", 32'h44, 32'h401003B3, 2);  // SUB x7,x0,x1
      fetch("f48", 32'h48, 32'h00730433, 2);  // ADD x8,x6,x7
      fetch("f4c", 32'h4C, 32'h00802E23, 2);  // SW x8,28(x0)
      mem("sw_x8", 1'b1, 32'd28, 32'h1234_4FCC, 0, 32'd0);
      chk("ret_prog", 32'(n_ret), 32'd20);

      fetch("f50", 32'h50, 32'h00000073, 0);  // ECALL: illegal here
`ifdef X_CORE_RV32I_MC_TRAP_EN
      repeat (10) @(negedge i_clk);
      chk("halt_trap", 32'(o_trap), 32'd1);
      chk("halt_valid", 32'(bus.o_valid), 32'd0);
      chk("halt_ret", 32'(n_ret), 32'd20);
`else
      wait_req("nop", 2);
      chk("nop_addr", bus.o_addr, 32'h54);
      chk("nop_trap", 32'(o_trap), 32'd0);
      chk("nop_ret", 32'(n_ret), 32'd21);
`endif

      // Reset with a request accepted on the same edge: the accept must be dropped.
      i_rst        = 1'b1;
      bus.i_accept = 1'b1;
      bus.i_data   = 32'h00500093;
      #1;
      chk("rst2_valid", 32'(bus.o_valid), 32'd0);
      chk("rst2_trap", 32'(o_trap), 32'd0);
      @(negedge i_clk);
      i_rst        = 1'b0;
      bus.i_accept = 1'b0;
      bus.i_data   = '0;
      #1;
      fetch("r0", 32'h00, 32'h00102C23, 0);   // SW x1,24(x0): x1 cleared by reset
      mem("sw_rst", 1'b1, 32'd24, 32'd0, 0, 32'd0);
      fetch("r4", 32'h04, 32'h00000013, 0);
      chk("ret_rst", 32'(n_ret), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/x_core_rv32i_mc.md
Name: x_core_rv32i_mc

Overview:
Parametrised multi-cycle RV32I integer core. It is the successor to the single-format OP-IMM fetch/execute core. It executes the full RV32I base integer set except FENCE/ECALL/EBREAK/CSR, and supports word-only loads and stores. It talks to one shared instruction/data memory through a valid/accept handshake, and sits directly under the peripheral top level.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NUM_REGS, 32, register file depth. Legal values are 16 (RV32E-style) and 32. A register index >= NUM_REGS is an illegal instruction.
BYTE_ADDR_CHECK, 1, when 1, a misaligned load/store or jump target is an illegal instruction. When 0, addr[1:0] is forced to 0.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_data  input  32  memory read data; valid in the cycle i_accept=1
i_accept  input  1  memory accepts the current request this cycle
o_valid  output  1  memory request pending
o_we  output  1  1 = write request, 0 = read request
o_addr  output  32  request byte address, word aligned
o_data  output  32  write data; 0 when o_we=0
o_retire  output  1  one-cycle pulse per completed instruction
o_trap  output  1  high while halted on an illegal instruction

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge of i_clk):
  - pc = RESET_PC, all registers = 0, state = FETCH, instruction register = 0.
  - Outputs during reset: o_valid=0, o_we=0, o_addr=0, o_data=0, o_retire=0, o_trap=0.
  - Reset wins over any in-flight request. A request accepted in the same cycle as reset is discarded.
- States: FETCH, DECODE, EXECUTE, MEM, HALT.
- FETCH:
  - o_valid=1, o_we=0, o_addr=pc.
  - Held until i_accept=1. i_data is then latched into the instruction register and the state goes to DECODE.
- DECODE (1 cycle):
  - Read rs1/rs2 into operand registers and form the sign-extended immediate (I/S/B/U/J format).
  - Classify the opcode; go to EXECUTE, or to HALT if illegal.
- EXECUTE (1 cycle):
  - OP and OP-IMM: ADD/SUB, SLL/SRL/SRA (shift amount [4:0]), SLT (signed), SLTU, XOR, OR, AND. Write rd; pc += 4.
  - LUI: rd = imm. AUIPC: rd = pc + imm. pc += 4.
  - JAL: rd = pc+4; pc = pc + imm. JALR: rd = pc+4; pc = (rs1 + imm) & ~1.
  - BRANCH: BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU. pc = taken ? pc + imm : pc + 4.
  - LW/SW: compute address rs1 + imm, go to MEM.
  - All other instructions go to FETCH with o_retire=1.
- MEM:
  - o_valid=1, o_addr = effective address, o_we=1 for SW with o_data=rs2.
  - Held stable until i_accept. On accept: LW writes rd with i_data, pc += 4, o_retire=1, state goes to FETCH.
- Register x0: writes to x0 are ignored; reads of x0 always return 0.
- Arithmetic wraps modulo 2^32. PC wraps from 32'hFFFF_FFFC to 0.
- Latency: ALU/branch/jump instructions take 3 cycles after fetch accept. Loads/stores take 3 cycles plus MEM wait.
- Handshake: o_valid, o_we, o_addr and o_data must not change while o_valid=1 and i_accept=0. i_accept while o_valid=0 is ignored.
- Illegal instruction: unsupported opcode/funct, LB/LH/LBU/LHU/SB/SH, register index >= NUM_REGS, or misaligned address with BYTE_ADDR_CHECK=1.
  - The state goes to HALT; pc and registers are unchanged.
  - HALT exits only on reset.

Optional Feature:
X_CORE_RV32I_MC_TRAP_EN
- Defined: illegal instruction enters HALT with o_trap=1 and o_valid=0 until reset.
- Undefined: illegal instruction executes as a NOP: pc += 4, o_retire=1, no register write, o_trap tied to 0. HALT is unreachable.

Test Plan:
1. Reset then ADDI x1,x0,5 (32'h00500093), accept immediately -> fetch at addr 0; x1=5 after 3 cycles; one o_retire pulse; next fetch at addr 4.
2. ADDI x2,x0,-1 then SRAI x3,x2,4 then SRLI x4,x2,28 -> x3=32'hFFFF_FFFF, x4=32'h0000_000F.
3. BLT x2,x1,+8 with x2=-1 and x1=5 -> next fetch at pc+8. Repeat with BLTU -> not taken, next fetch at pc+4.
4. SW x1,12(x0), then LW x5,12(x0) with i_accept delayed 3 cycles -> request o_we=1, o_addr=12, o_data=5 held stable through the stall; LW read at addr 12; x5 = returned i_data.
5. JAL x1,+16 at pc=8, then JALR x0,0(x1) -> x1=12, fetch at 24, then fetch at 12. ADDI x0,x0,7 -> x0 reads 0.
6. Opcode 32'h0000_0073 with the trap macro defined -> o_trap=1, o_valid=0 held for 10 cycles. Assert i_rst -> fetch resumes at RESET_PC. Without the macro -> retired as NOP, pc += 4.
